// File: rtl/wb_interconnect_pkg.sv
// Shared types and helpers for the N x M Wishbone crossbar.
// Address ranges are held in a fixed 16-entry table with 64-bit fields.
// Crossbar instances with fewer slaves or narrower addresses zero-fill the unused parts.
package wb_interconnect_pkg;

  localparam int ADDR_MAX_W = 64;
  localparam int MAX_SLAVES = 16;
  localparam int SLV_IDX_W  = 5;
  localparam int CTI_W      = 3;
  localparam int BTE_W      = 2;

  // Decode result when no range matches; the top maps it onto the error slave.
  localparam logic [SLV_IDX_W-1:0] NO_SLAVE = 5'h1f;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] base;
    logic [ADDR_MAX_W-1:0] limit;
  } addr_range_t;

  typedef addr_range_t [MAX_SLAVES-1:0] range_tbl_t;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  // Scan from the top entry down so that the lowest matching index wins on overlap.
  function automatic logic [SLV_IDX_W-1:0] decode_addr(input logic [ADDR_MAX_W-1:0] adr,
                                                       input range_tbl_t ranges,
                                                       input int n_slaves);
    logic [SLV_IDX_W-1:0] hit;
    hit = NO_SLAVE;
    for (int j = MAX_SLAVES - 1; j >= 0; j--) begin
      if (j < n_slaves && adr >= ranges[j].base && adr <= ranges[j].limit) begin
        hit = SLV_IDX_W'(j);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Per-slave round-robin arbiter with cycle lock and optional watchdog (WB_INTERCONNECT_TIMEOUT_EN).
// Latency: grant one cycle after request; release on the edge where the owner's CYC is low.
// Backpressure: losing requesters are simply not granted; stall until the owner drops CYC.
// Ports: req/cyc per master; owner STB/ACK/ERR for the watchdog.
// Outputs: gnt_vld/gnt_idx; to_err is a one-cycle timeout pulse; kill stays high until release.
module wb_rr_arbiter
  import wb_interconnect_pkg::*;
#(
  parameter int  N_MASTERS      = 4,
  parameter int  TIMEOUT_CYCLES = 256,
  localparam int IW             = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] cyc,
  input  logic                 own_stb,
  input  logic                 own_ack,
  input  logic                 own_err,
  output logic                 gnt_vld,
  output logic [IW-1:0]        gnt_idx,
  output logic                 to_err,
  output logic                 kill
);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] pick;
  logic          found;
  int            scan_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ARB_IDLE;
      owner <= '0;
      last  <= IW'(N_MASTERS - 1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    pick      = last;
    found     = 1'b0;
    scan_idx  = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      scan_idx = (int'(last) + k) % N_MASTERS;
      if (!found && req[scan_idx]) begin
        pick  = IW'(scan_idx);
        found = 1'b1;
      end
    end
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_nxt = ARB_GRANTED;
          owner_nxt = pick;
          last_nxt  = pick;
        end
      end
      ARB_GRANTED: begin
        // Only the owner's CYC ends the lock; no re-arbitration in this state.
        if (!cyc[owner]) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign gnt_vld = (state == ARB_GRANTED);
  assign gnt_idx = owner;

`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  logic          wd_pulse;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt   <= '0;
      wd_hit   <= 1'b0;
      wd_pulse <= 1'b0;
    end else begin
      wd_pulse <= 1'b0;
      if (!gnt_vld || !cyc[owner]) begin
        wd_cnt <= '0;
        wd_hit <= 1'b0;
      end else if (own_ack || own_err) begin
        wd_cnt <= '0;
      end else if (own_stb && !wd_hit) begin
        if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          wd_cnt   <= '0;
          wd_hit   <= 1'b1;
          wd_pulse <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end
  end

  assign to_err = wd_pulse;
  assign kill   = wd_hit;
`else
  logic unused_wd;
  assign unused_wd = ^{own_stb, own_ack, own_err};
  assign to_err    = 1'b0;
  assign kill      = 1'b0;
`endif

endmodule

// File: rtl/wb_interconnect_arb_nxm.sv
// N_MASTERS x N_SLAVES Wishbone crossbar with per-slave round-robin lock and error slave.
// Optional watchdog is enabled by WB_INTERCONNECT_TIMEOUT_EN.
// Latency: grant one cycle after request; the datapath is combinational both ways once granted.
// Backpressure: unowned requesters get no ACK/ERR until the owner drops CYC.
// Ports: flattened M_* master buses (master m at [m*W +: W]) and S_* slave buses (slave j at [j*W +: W]).
// clk and active-low asynchronous rstn.
module wb_interconnect_arb_nxm
  import wb_interconnect_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 4,
  parameter int N_SLAVES       = 3,
  parameter logic [N_SLAVES*2*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]   M_ADR,
  input  logic [N_MASTERS*CTI_W-1:0]           M_CTI,
  input  logic [N_MASTERS*BTE_W-1:0]           M_BTE,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]   M_DAT_W,
  input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0] M_SEL,
  input  logic [N_MASTERS-1:0]                 M_CYC,
  input  logic [N_MASTERS-1:0]                 M_STB,
  input  logic [N_MASTERS-1:0]                 M_WE,
  output logic [N_MASTERS*WB_DATA_WIDTH-1:0]   M_DAT_R,
  output logic [N_MASTERS-1:0]                 M_ACK,
  output logic [N_MASTERS-1:0]                 M_ERR,
  output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]    S_ADR,
  output logic [N_SLAVES*CTI_W-1:0]            S_CTI,
  output logic [N_SLAVES*BTE_W-1:0]            S_BTE,
  output logic [N_SLAVES*WB_DATA_WIDTH-1:0]    S_DAT_W,
  output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0]  S_SEL,
  output logic [N_SLAVES-1:0]                  S_CYC,
  output logic [N_SLAVES-1:0]                  S_STB,
  output logic [N_SLAVES-1:0]                  S_WE,
  input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]    S_DAT_R,
  input  logic [N_SLAVES-1:0]                  S_ACK,
  input  logic [N_SLAVES-1:0]                  S_ERR
);

  localparam int AW   = WB_ADDR_WIDTH;
  localparam int DW   = WB_DATA_WIDTH;
  localparam int SELW = WB_DATA_WIDTH / 8;
  localparam int MIW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SW   = $clog2(N_SLAVES + 1);

  // Slave 0 occupies the most significant {base, limit} pair.
  function automatic range_tbl_t build_ranges();
    range_tbl_t r;
    r = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      r[j].base  = ADDR_MAX_W'(ADDR_RANGES[(N_SLAVES - j)*2*AW - 1 -: AW]);
      r[j].limit = ADDR_MAX_W'(ADDR_RANGES[(N_SLAVES - j)*2*AW - AW - 1 -: AW]);
    end
    return r;
  endfunction

  localparam range_tbl_t RANGES = build_ranges();

  logic [SLV_IDX_W-1:0] dec_raw [N_MASTERS];
  logic [SW-1:0]        tgt     [N_MASTERS];
  logic [N_MASTERS-1:0] req     [N_SLAVES+1];
  logic [MIW-1:0]       gnt_idx [N_SLAVES+1];
  logic [N_SLAVES:0]    gnt_vld, to_err, kill;
  logic [N_SLAVES:0]    own_stb, own_ack, own_err;
  logic                 err_q;

  // Target index N_SLAVES is the internal error slave.
  for (genvar m = 0; m < N_MASTERS; m++) begin : g_dec
    assign dec_raw[m] = decode_addr(ADDR_MAX_W'(M_ADR[m*AW +: AW]), RANGES, N_SLAVES);
    assign tgt[m]     = (dec_raw[m] == NO_SLAVE) ? SW'(N_SLAVES) : dec_raw[m][SW-1:0];
  end

  always_comb begin
    for (int j = 0; j <= N_SLAVES; j++) req[j] = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      for (int j = 0; j <= N_SLAVES; j++) begin
        if (tgt[m] == SW'(j)) req[j][m] = M_CYC[m] & M_STB[m];
      end
    end
  end

  for (genvar j = 0; j <= N_SLAVES; j++) begin : g_arb
    assign own_stb[j] = M_STB[gnt_idx[j]];
    if (j < N_SLAVES) begin : g_real
      assign own_ack[j] = S_ACK[j];
      assign own_err[j] = S_ERR[j];
    end else begin : g_errslv
      assign own_ack[j] = 1'b0;
      assign own_err[j] = err_q;
    end

    wb_rr_arbiter #(
      .N_MASTERS      (N_MASTERS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req[j]),
      .cyc     (M_CYC),
      .own_stb (own_stb[j]),
      .own_ack (own_ack[j]),
      .own_err (own_err[j]),
      .gnt_vld (gnt_vld[j]),
      .gnt_idx (gnt_idx[j]),
      .to_err  (to_err[j]),
      .kill    (kill[j])
    );
  end

  // Error responder: one ERR per sampled STB; the !err_q term keeps a held STB
  // from producing a back-to-back second error for the same beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= gnt_vld[N_SLAVES] & own_stb[N_SLAVES] & ~kill[N_SLAVES] & ~err_q;
  end

  always_comb begin
    S_ADR   = '0;
    S_CTI   = '0;
    S_BTE   = '0;
    S_DAT_W = '0;
    S_SEL   = '0;
    S_CYC   = '0;
    S_STB   = '0;
    S_WE    = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (gnt_vld[j]) begin
        S_ADR[j*AW +: AW]         = M_ADR[int'(gnt_idx[j])*AW +: AW];
        S_CTI[j*CTI_W +: CTI_W]   = M_CTI[int'(gnt_idx[j])*CTI_W +: CTI_W];
        S_BTE[j*BTE_W +: BTE_W]   = M_BTE[int'(gnt_idx[j])*BTE_W +: BTE_W];
        S_DAT_W[j*DW +: DW]       = M_DAT_W[int'(gnt_idx[j])*DW +: DW];
        S_SEL[j*SELW +: SELW]     = M_SEL[int'(gnt_idx[j])*SELW +: SELW];
        S_WE[j]                   = M_WE[gnt_idx[j]];
        S_CYC[j]                  = M_CYC[gnt_idx[j]] & ~kill[j];
        S_STB[j]                  = M_STB[gnt_idx[j]] & ~kill[j];
      end
    end
  end

  always_comb begin
    M_DAT_R = '0;
    M_ACK   = '0;
    M_ERR   = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (gnt_vld[j] && !kill[j]) begin
        M_DAT_R[int'(gnt_idx[j])*DW +: DW] = M_DAT_R[int'(gnt_idx[j])*DW +: DW] | S_DAT_R[j*DW +: DW];
        M_ACK[gnt_idx[j]] = M_ACK[gnt_idx[j]] | S_ACK[j];
        M_ERR[gnt_idx[j]] = M_ERR[gnt_idx[j]] | S_ERR[j];
      end
    end
    for (int j = 0; j <= N_SLAVES; j++) begin
      if (gnt_vld[j]) M_ERR[gnt_idx[j]] = M_ERR[gnt_idx[j]] | to_err[j];
    end
    if (gnt_vld[N_SLAVES]) M_ERR[gnt_idx[N_SLAVES]] = M_ERR[gnt_idx[N_SLAVES]] | err_q;
  end

endmodule

// File: tb/tb_wb_interconnect_arb_nxm.sv
// Scoreboard bench for the 4x3 Wishbone crossbar.
// Directed transfers push expected grants/responses into queues.
// A negedge monitor pops and compares them.
module tb_wb_interconnect_arb_nxm;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [127:0] M_ADR, M_DAT_W, M_DAT_R;
  logic [11:0]  M_CTI;
  logic [7:0]   M_BTE;
  logic [15:0]  M_SEL;
  logic [3:0]   M_CYC, M_STB, M_WE, M_ACK, M_ERR;
  logic [95:0]  S_ADR, S_DAT_W, S_DAT_R;
  logic [8:0]   S_CTI;
  logic [5:0]   S_BTE;
  logic [11:0]  S_SEL;
  logic [2:0]   S_CYC, S_STB, S_WE, S_ACK, S_ERR;

  logic [31:0]  m_adr [4];
  logic [31:0]  m_dat [4];
  logic [3:0]   m_cyc = '0, m_stb = '0, m_we = '0;
  logic [2:0]   ack_en = 3'b111;
  logic [2:0]   s_ack;

  int n_chk = 0, n_pass = 0, cnt = 0;
  int start_cnt [4], drop_cnt [4], resp_cnt [4], rise_cnt [3];
  logic [2:0] scyc_at_resp [4];
  logic [2:0] prev_scyc = '0;

  typedef struct {int m; logic err; logic chkd; logic [31:0] dat;} rsp_t;
  typedef struct {int j; logic [31:0] adr; logic we; logic [31:0] dw; logic [2:0] cti;} gnt_t;
  rsp_t rsp_q[$];
  gnt_t gnt_q[$];

  assign M_ADR   = {m_adr[3], m_adr[2], m_adr[1], m_adr[0]};
  assign M_DAT_W = {m_dat[3], m_dat[2], m_dat[1], m_dat[0]};
  assign M_CTI   = {3'd3, 3'd2, 3'd1, 3'd0};
  assign M_BTE   = '0;
  assign M_SEL   = '1;
  assign M_CYC   = m_cyc;
  assign M_STB   = m_stb;
  assign M_WE    = m_we;
  assign S_DAT_R = {32'h22222222, 32'hCAFEF00D, 32'h00C0FFEE};
  assign S_ACK   = s_ack;
  assign S_ERR   = '0;

  wb_interconnect_arb_nxm #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .N_MASTERS     (4),
    .N_SLAVES      (3),
    .ADDR_RANGES   ({32'h0000_0000, 32'h0000_0FFF, 32'h0000_1000, 32'h0000_1FFF,
                     32'h8000_0000, 32'h8000_FFFF}),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .M_ADR(M_ADR), .M_CTI(M_CTI), .M_BTE(M_BTE), .M_DAT_W(M_DAT_W), .M_SEL(M_SEL),
    .M_CYC(M_CYC), .M_STB(M_STB), .M_WE(M_WE),
    .M_DAT_R(M_DAT_R), .M_ACK(M_ACK), .M_ERR(M_ERR),
    .S_ADR(S_ADR), .S_CTI(S_CTI), .S_BTE(S_BTE), .S_DAT_W(S_DAT_W), .S_SEL(S_SEL),
    .S_CYC(S_CYC), .S_STB(S_STB), .S_WE(S_WE),
    .S_DAT_R(S_DAT_R), .S_ACK(S_ACK), .S_ERR(S_ERR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  // Bench slaves: registered ACK one cycle after each sampled STB.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) s_ack <= '0;
    else       s_ack <= S_CYC & S_STB & ~s_ack & ack_en;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s", name);
  endtask

  task automatic exp_rsp(input int m, input logic err, input logic chkd, input logic [31:0] dat);
    rsp_t e;
    e.m = m; e.err = err; e.chkd = chkd; e.dat = dat;
    rsp_q.push_back(e);
  endtask

  task automatic exp_gnt(input int j, input logic [31:0] adr, input logic we,
                         input logic [31:0] dw, input logic [2:0] cti);
    gnt_t e;
    e.j = j; e.adr = adr; e.we = we; e.dw = dw; e.cti = cti;
    gnt_q.push_back(e);
  endtask

  task automatic xfer(input int m, input logic [31:0] adr, input logic we,
                      input logic [31:0] wd, input int beats);
    int n;
    @(posedge clk); #1;
    m_adr[m] = adr; m_dat[m] = wd; m_we[m] = we; m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
    start_cnt[m] = cnt;
    for (int b = 0; b < beats; b++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(M_ACK[m] || M_ERR[m]) && n < 100);
      if (!(M_ACK[m] || M_ERR[m])) fail($sformatf("m%0d_beat%0d_timeout", m, b));
      @(posedge clk); #1;
    end
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    drop_cnt[m] = cnt;
  endtask

  // Monitor: every ACK/ERR and every slave grant must match a queued expectation.
  int ri, gi;
  always @(negedge clk) begin
    if (rstn) begin
      for (int m = 0; m < 4; m++) begin
        if (M_ACK[m] || M_ERR[m]) begin
          resp_cnt[m] = cnt;
          scyc_at_resp[m] = S_CYC;
          ri = -1;
          for (int i = rsp_q.size() - 1; i >= 0; i--) if (rsp_q[i].m == m) ri = i;
          if (ri < 0) fail($sformatf("m%0d_unexpected_resp ack=%0b err=%0b", m, M_ACK[m], M_ERR[m]));
          else begin
            chk($sformatf("m%0d_resp_kind", m), {62'd0, M_ACK[m], M_ERR[m]},
                rsp_q[ri].err ? 64'd1 : 64'd2);
            if (rsp_q[ri].chkd) chk($sformatf("m%0d_dat_r", m), 64'(M_DAT_R[m*32 +: 32]), 64'(rsp_q[ri].dat));
            rsp_q.delete(ri);
          end
        end
      end
      for (int j = 0; j < 3; j++) begin
        if (S_CYC[j] && !prev_scyc[j]) begin
          rise_cnt[j] = cnt;
          gi = -1;
          for (int i = gnt_q.size() - 1; i >= 0; i--) if (gnt_q[i].j == j) gi = i;
          if (gi < 0) fail($sformatf("s%0d_unexpected_grant adr=%0h", j, S_ADR[j*32 +: 32]));
          else begin
            chk($sformatf("s%0d_grant_adr_we_cti", j), {28'd0, S_ADR[j*32 +: 32], S_WE[j], S_CTI[j*3 +: 3]},
                {28'd0, gnt_q[gi].adr, gnt_q[gi].we, gnt_q[gi].cti});
            if (gnt_q[gi].we) chk($sformatf("s%0d_dat_w", j), 64'(S_DAT_W[j*32 +: 32]), 64'(gnt_q[gi].dw));
            gnt_q.delete(gi);
          end
        end
      end
    end
    prev_scyc = S_CYC;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    for (int m = 0; m < 4; m++) begin m_adr[m] = '0; m_dat[m] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 64'(|{M_DAT_R, M_ACK, M_ERR, S_ADR, S_CTI, S_BTE, S_DAT_W, S_SEL,
                                    S_CYC, S_STB, S_WE}), 64'd0);
    @(posedge clk); #1; rstn = 1'b1;

    // Single access: M0 reads S1.
    exp_gnt(1, 32'h1004, 1'b0, 32'h0, 3'd0);
    exp_rsp(0, 1'b0, 1'b1, 32'hCAFEF00D);
    xfer(0, 32'h1004, 1'b0, 32'h0, 1);
    chk("single_grant_latency", 64'(rise_cnt[1] - start_cnt[0]), 64'd1);
    chk("single_ack_latency", 64'(resp_cnt[0] - start_cnt[0]), 64'd2);

    // Round-robin on S0: expected order 0,1,2,3,0.
    exp_gnt(0, 32'h10, 1'b0, 32'h0, 3'd0);
    exp_gnt(0, 32'h20, 1'b1, 32'hA1A1A1A1, 3'd1);
    exp_gnt(0, 32'h30, 1'b0, 32'h0, 3'd2);
    exp_gnt(0, 32'h40, 1'b0, 32'h0, 3'd3);
    exp_gnt(0, 32'h14, 1'b0, 32'h0, 3'd0);
    exp_rsp(0, 1'b0, 1'b1, 32'h00C0FFEE);
    exp_rsp(0, 1'b0, 1'b1, 32'h00C0FFEE);
    exp_rsp(1, 1'b0, 1'b0, 32'h0);
    exp_rsp(2, 1'b0, 1'b1, 32'h00C0FFEE);
    exp_rsp(3, 1'b0, 1'b1, 32'h00C0FFEE);
    fork
      begin xfer(0, 32'h10, 1'b0, 32'h0, 1); xfer(0, 32'h14, 1'b0, 32'h0, 1); end
      xfer(1, 32'h20, 1'b1, 32'hA1A1A1A1, 1);
      xfer(2, 32'h30, 1'b0, 32'h0, 1);
      xfer(3, 32'h40, 1'b0, 32'h0, 1);
    join

    // Concurrency: M0->S0 and M2->S2 granted in the same cycle.
    exp_gnt(0, 32'h100, 1'b0, 32'h0, 3'd0);
    exp_gnt(2, 32'h80000010, 1'b0, 32'h0, 3'd2);
    exp_rsp(0, 1'b0, 1'b1, 32'h00C0FFEE);
    exp_rsp(2, 1'b0, 1'b1, 32'h22222222);
    fork
      xfer(0, 32'h100, 1'b0, 32'h0, 1);
      xfer(2, 32'h80000010, 1'b0, 32'h0, 1);
    join
    chk("concurrent_same_grant_cycle", 64'(rise_cnt[0] - rise_cnt[2]), 64'd0);
    chk("concurrent_grant_latency", 64'(rise_cnt[2] - start_cnt[2]), 64'd1);

    // Decode error: unmapped write terminated by the error slave.
    exp_rsp(1, 1'b1, 1'b0, 32'h0);
    xfer(1, 32'h4000, 1'b1, 32'h55AA55AA, 1);
    chk("decode_err_latency", 64'(resp_cnt[1] - start_cnt[1]), 64'd2);
    chk("decode_err_no_scyc", 64'(scyc_at_resp[1]), 64'd0);

    // Lock: M3 holds S1 for 4 beats; M0 waits until release plus one cycle.
    exp_gnt(1, 32'h1000, 1'b0, 32'h0, 3'd3);
    exp_gnt(1, 32'h1008, 1'b1, 32'h12345678, 3'd0);
    for (int b = 0; b < 4; b++) exp_rsp(3, 1'b0, 1'b1, 32'hCAFEF00D);
    exp_rsp(0, 1'b0, 1'b0, 32'h0);
    fork
      xfer(3, 32'h1000, 1'b0, 32'h0, 4);
      begin repeat (2) @(posedge clk); xfer(0, 32'h1008, 1'b1, 32'h12345678, 1); end
      begin
        repeat (6) @(negedge clk);
        chk("lock_m0_stalled_zero", {30'd0, M_ACK[0], M_ERR[0], M_DAT_R[31:0]}, 64'd0);
      end
    join
    chk("lock_regrant_gap", 64'(rise_cnt[1] - drop_cnt[3]), 64'd2);

`ifdef WB_INTERCONNECT_TIMEOUT_EN
    // Watchdog: S2 never acks.
    ack_en[2] = 1'b0;
    exp_gnt(2, 32'h80000040, 1'b0, 32'h0, 3'd2);
    exp_rsp(2, 1'b1, 1'b0, 32'h0);
    xfer(2, 32'h80000040, 1'b0, 32'h0, 1);
    chk("watchdog_err_latency", 64'(resp_cnt[2] - start_cnt[2]), 64'd9);
    chk("watchdog_scyc2_low", 64'(scyc_at_resp[2][2]), 64'd0);
    ack_en[2] = 1'b1;
`endif

    // Asynchronous reset in the middle of a stalled transfer.
    ack_en[2] = 1'b0;
    exp_gnt(2, 32'h80000020, 1'b0, 32'h0, 3'd2);
    @(posedge clk); #1;
    m_adr[2] = 32'h80000020; m_we[2] = 1'b0; m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_scyc2", 64'(S_CYC[2]), 64'd1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs_zero", 64'(|{M_DAT_R, M_ACK, M_ERR, S_ADR, S_CTI, S_BTE, S_DAT_W, S_SEL,
                                          S_CYC, S_STB, S_WE}), 64'd0);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    ack_en[2] = 1'b1;
    @(posedge clk); #1; rstn = 1'b1;

    // After reset the pointer is N_MASTERS-1, so M0 beats M3 to S0.
    exp_gnt(0, 32'h200, 1'b0, 32'h0, 3'd0);
    exp_gnt(0, 32'h300, 1'b0, 32'h0, 3'd3);
    exp_rsp(0, 1'b0, 1'b1, 32'h00C0FFEE);
    exp_rsp(3, 1'b0, 1'b1, 32'h00C0FFEE);
    fork
      xfer(0, 32'h200, 1'b0, 32'h0, 1);
      xfer(3, 32'h300, 1'b0, 32'h0, 1);
    join

    repeat (4) @(posedge clk);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    chk("grant_queue_drained", 64'(gnt_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
